// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and alu_share_arbiter.
// Requesters use the master modport, the arbiter uses the slave modport.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb;
  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_data;

  modport master (
    output req_valid, req_srca, req_srcb, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_srca, req_srcb, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters,
// operands and result registered around it. Optional perf ports: ALU_SHARE_ARBITER_PERF_EN.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_share_arbiter_if.slave       bus,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
`ifdef ALU_SHARE_ARBITER_PERF_EN
  ,
  output logic [31:0]              op_count,
  output logic                     busy
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_srca;
  logic [DATA_WIDTH-1:0]    r_srcb;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]    r_result;
  logic [IDX_W-1:0]         r_owner;
  logic [IDX_W-1:0]         r_last_grant;
  logic [NUM_REQ-1:0]       r_rsp_valid;

  logic                     w_grant_valid;
  logic [IDX_W-1:0]         w_grant_idx;
  logic [NUM_REQ-1:0]       w_req_ready;
  logic [NUM_REQ-1:0]       w_owner_onehot;
  logic [DATA_WIDTH-1:0]    w_srca [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_srcb [NUM_REQ];
  logic [OPCODE_LENGTH-1:0] w_op   [NUM_REQ];

  // Unpack the flattened request buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_srca[i] = bus.req_srca[i*DATA_WIDTH +: DATA_WIDTH];
      w_srcb[i] = bus.req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
      w_op[i]   = bus.req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
    end
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    int cand;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    cand          = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_grant_valid && bus.req_valid[IDX_W'(cand)]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = IDX_W'(cand);
      end else begin
        w_grant_valid = w_grant_valid;
      end
    end
  end

  // Grant is only offered while idle.
  always_comb begin
    w_req_ready = '0;
    if (r_state == IDLE && w_grant_valid) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

  // Control FSM with operand, result and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_srca       <= '0;
      r_srcb       <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_owner      <= '0;
      r_last_grant <= LAST_RST;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_srca       <= w_srca[w_grant_idx];
            r_srcb       <= w_srcb[w_grant_idx];
            r_op         <= w_op[w_grant_idx];
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_state      <= EXEC;
          end else begin
            r_state      <= IDLE;
          end
        end
        EXEC: begin
          r_result    <= alu_result;
          r_rsp_valid <= w_owner_onehot;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready completes the response.
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end else begin
            r_state     <= RESP;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic [31:0] r_op_count;

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count <= 32'd0;
    end else if (r_state == RESP && bus.rsp_ready[r_owner] && r_op_count != 32'hFFFF_FFFF) begin
      r_op_count <= r_op_count + 32'd1;
    end else begin
      r_op_count <= r_op_count;
    end
  end

  assign op_count = r_op_count;
  assign busy     = (r_state != IDLE);
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_result;
  assign alu_srca       = r_srca;
  assign alu_srcb       = r_srcb;
  assign alu_operation  = r_op;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small reference ALU attached.
// Define ALU_SHARE_ARBITER_PERF_EN to also exercise op_count/busy.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) bus ();

  logic [DW-1:0] alu_srca;
  logic [DW-1:0] alu_srcb;
  logic [DW-1:0] alu_result;
  logic [OW-1:0] alu_operation;
`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic [31:0] op_count;
  logic        busy;
`endif

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .alu_srca      (alu_srca),
    .alu_srcb      (alu_srcb),
    .alu_operation (alu_operation),
    .alu_result    (alu_result)
`ifdef ALU_SHARE_ARBITER_PERF_EN
    ,
    .op_count      (op_count),
    .busy          (busy)
`endif
  );

  // Reference combinational ALU: AND, OR, ADD, SUB, SLT; other codes give 0.
  always_comb begin
    case (alu_operation)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0110: alu_result = alu_srca - alu_srcb;
      4'b0111: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = 32'd0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req_srca[r*DW +: DW] = a;
    bus.req_srcb[r*DW +: DW] = b;
    bus.req_op[r*OW +: OW]   = op;
  endtask

  // One isolated operation from requester r; starts and ends just after a rising edge with the DUT idle.
  task automatic run_single(input int r, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] exp);
    logic [1:0] oh;
    int lat;
    oh = 2'b01 << r;
    bus.rsp_ready = 2'b11;
    set_req(r, a, b, op);
    bus.req_valid = oh;
    @(negedge clk);
    check("single_req_ready", bus.req_ready, oh);
`ifdef ALU_SHARE_ARBITER_PERF_EN
    check("busy_idle", busy, 1'b0);
`endif
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    lat = 0;
    while (bus.rsp_valid == 2'b00 && lat < 6) begin
      @(negedge clk);
      lat++;
`ifdef ALU_SHARE_ARBITER_PERF_EN
      check("busy_active", busy, 1'b1);
`endif
    end
    check("single_latency", lat, 2);
    check("single_rsp_valid", bus.rsp_valid, oh);
    check("single_rsp_data", bus.rsp_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_srca  = '0;
    bus.req_srcb  = '0;
    bus.req_op    = '0;

    // Reset state
    #12;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_alu_srca", alu_srca, 32'd0);
    check("rst_alu_op", alu_operation, 4'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD on requester 0, SUB on requester 1
    run_single(0, 32'd5, 32'd3, 4'b0010, 32'd8);
    run_single(1, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE);

    // Both requesting continuously: grants alternate 0,1,0,1 every 3 cycles
    bus.rsp_ready = 2'b11;
    set_req(0, 32'd10, 32'd1, 4'b0010);
    set_req(1, 32'd10, 32'd1, 4'b0110);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      int g;
      @(negedge clk);
      g = (c / 3) % 2;
      check("rr_req_ready", bus.req_ready, (c % 3 == 0) ? (2'b01 << g) : 2'b00);
      check("rr_rsp_valid", bus.rsp_valid, (c % 3 == 2) ? (2'b01 << g) : 2'b00);
      if (c % 3 == 2) begin
        check("rr_rsp_data", bus.rsp_data, (g == 0) ? 32'd11 : 32'd9);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;

    // Back-pressure on requester 0 while requester 1 waits; non-owner rsp_ready ignored
    bus.rsp_ready = 2'b10;
    set_req(0, 32'd7, 32'd2, 4'b0000);
    set_req(1, 32'd7, 32'd2, 4'b0001);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("bp_grant0", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("bp_exec_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    check("bp_rsp_valid", bus.rsp_valid, 2'b01);
    check("bp_rsp_data", bus.rsp_data, 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 2'b01);
      check("bp_hold_data", bus.rsp_data, 32'd2);
      check("bp_hold_ready", bus.req_ready, 2'b00);
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_grant1", bus.req_ready, 2'b10);
    check("bp_rsp_cleared", bus.rsp_valid, 2'b00);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("bp_rsp1_valid", bus.rsp_valid, 2'b10);
    check("bp_rsp1_data", bus.rsp_data, 32'd7);
    @(posedge clk); #1;

    // Async reset while requester 0's op is in EXEC
    set_req(0, 32'h0000_00F0, 32'h0000_000F, 4'b0011);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("rst_mid_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("rst_mid_exec_op", alu_operation, 4'b0011);
    check("rst_mid_exec_srca", alu_srca, 32'h0000_00F0);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_mid_alu_srca", alu_srca, 32'd0);
    check("rst_mid_alu_op", alu_operation, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", bus.rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd2, 4'b0010);
    set_req(1, 32'd4, 32'd4, 4'b0010);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("rst_next_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_next_rsp_valid", bus.rsp_valid, 2'b01);
    check("rst_next_rsp_data", bus.rsp_data, 32'd3);
    @(posedge clk); #1;

`ifdef ALU_SHARE_ARBITER_PERF_EN
    // One op completed since reset; nine more make ten
    check("perf_count_1", op_count, 32'd1);
    for (int i = 0; i < 9; i++) begin
      run_single(i % 2, i, 32'd1, 4'b0010, i + 1);
    end
    check("perf_count_10", op_count, 32'd10);
    check("perf_busy_idle", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
